// File: rtl/pipelined_exec_core.sv
// Three-stage RV32I-format execute core: ID register -> combinational EX -> WB register.
// Instruction words arrive from an external fetch unit over a valid/ready handshake.
// Taken branches redirect fetch and drop the younger word; a halt opcode freezes the
// core until reset.
module pipelined_exec_core #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned REG_DEPTH  = 32,
    parameter int unsigned ADDR_WIDTH = 7
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [31:0]                  in_instr,
    input  logic [ADDR_WIDTH-1:0]        in_pc,
    output logic                         redirect_valid,
    output logic [ADDR_WIDTH-1:0]        redirect_addr,
    output logic                         res_valid,
    output logic [$clog2(REG_DEPTH)-1:0] res_reg,
    output logic [DATA_WIDTH-1:0]        res_data,
    output logic                         halted,
    input  logic [$clog2(REG_DEPTH)-1:0] dbg_addr,
    output logic [DATA_WIDTH-1:0]        dbg_data
);
    localparam int unsigned RW = $clog2(REG_DEPTH);
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_HALT = 7'b1111111;
    localparam logic [5:0] DW6     = 6'(DATA_WIDTH);

    logic                  id_valid_q;
    logic [31:0]           id_instr_q;
    logic [ADDR_WIDTH-1:0] id_pc_q;
    logic                  wb_valid_q;
    logic [RW-1:0]         wb_rd_q;
    logic [DATA_WIDTH-1:0] wb_data_q;
    logic                  halted_q;
    logic [DATA_WIDTH-1:0] regs_q [REG_DEPTH];

    logic [6:0]            opcode;
    logic [2:0]            func3;
    logic [6:0]            func7;
    logic [RW-1:0]         rd_idx, rs1_idx, rs2_idx;
    logic [31:0]           imm_i, imm_b;
    logic [DATA_WIDTH-1:0] op_a, rs2_val, op_b;
    logic [31:0]           op_b_ext;
    logic [4:0]            shamt;
    logic                  is_r, is_i, f7_base, f7_alt;
    logic [DATA_WIDTH-1:0] alu_res;
    logic                  alu_ok;
    logic                  br_taken, halt_in_ex, accept, wb_valid_d;

    assign opcode  = id_instr_q[6:0];
    assign func3   = id_instr_q[14:12];
    assign func7   = id_instr_q[31:25];
    assign rd_idx  = RW'(id_instr_q[11:7]);
    assign rs1_idx = RW'(id_instr_q[19:15]);
    assign rs2_idx = RW'(id_instr_q[24:20]);
    assign imm_i   = {{20{id_instr_q[31]}}, id_instr_q[31:20]};
    assign imm_b   = {{19{id_instr_q[31]}}, id_instr_q[31], id_instr_q[7],
                      id_instr_q[30:25], id_instr_q[11:8], 1'b0};

    assign is_r    = (opcode == OP_R);
    assign is_i    = (opcode == OP_I);
    assign f7_base = (func7 == 7'b0000000);
    assign f7_alt  = (func7 == 7'b0100000);

    // Operand read: x0 is hard zero, otherwise forward the pending WB write over the file.
    always_comb begin
        op_a    = '0;
        rs2_val = '0;
        if (rs1_idx != '0) begin
            op_a = (wb_valid_q && wb_rd_q == rs1_idx) ? wb_data_q : regs_q[rs1_idx];
        end
        if (rs2_idx != '0) begin
            rs2_val = (wb_valid_q && wb_rd_q == rs2_idx) ? wb_data_q : regs_q[rs2_idx];
        end
    end

    assign op_b     = is_i ? DATA_WIDTH'(imm_i) : rs2_val;
    assign op_b_ext = 32'(op_b);
    assign shamt    = 5'(op_b_ext);

    // ALU decode for R-type and I-type; undefined func3/func7 combinations leave alu_ok low.
    always_comb begin
        alu_res = '0;
        alu_ok  = 1'b0;
        if (is_r || is_i) begin
            case (func3)
                3'b000: begin
                    if (is_i || f7_base) begin
                        alu_ok  = 1'b1;
                        alu_res = op_a + op_b;
                    end else if (f7_alt) begin
                        alu_ok  = 1'b1;
                        alu_res = op_a - op_b;
                    end
                end
                3'b001: begin
                    alu_ok  = f7_base;
                    alu_res = ({1'b0, shamt} >= DW6) ? '0 : (op_a << shamt);
                end
                3'b101: begin
                    alu_ok = f7_base || f7_alt;
                    if ({1'b0, shamt} >= DW6) begin
                        alu_res = f7_alt ? {DATA_WIDTH{op_a[DATA_WIDTH-1]}} : '0;
                    end else begin
                        alu_res = f7_alt ? DATA_WIDTH'($signed(op_a) >>> shamt) : (op_a >> shamt);
                    end
                end
                3'b010: begin
                    alu_ok  = is_i || f7_base;
                    alu_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
                end
                3'b011: begin
                    alu_ok  = is_i || f7_base;
                    alu_res = {{(DATA_WIDTH-1){1'b0}}, (op_a < op_b)};
                end
                3'b100: begin
                    alu_ok  = is_i || f7_base;
                    alu_res = op_a ^ op_b;
                end
                3'b110: begin
                    alu_ok  = is_i || f7_base;
                    alu_res = op_a | op_b;
                end
                default: begin
                    alu_ok  = is_i || f7_base;
                    alu_res = op_a & op_b;
                end
            endcase
        end
    end

    assign br_taken = id_valid_q && (opcode == OP_BR) &&
                      (((func3 == 3'b000) && (op_a == rs2_val)) ||
                       ((func3 == 3'b001) && (op_a != rs2_val)));
    assign halt_in_ex = id_valid_q && (opcode == OP_HALT);

    assign redirect_valid = br_taken;
    assign redirect_addr  = br_taken ? ADDR_WIDTH'(32'(id_pc_q) + imm_b) : '0;

    // Gated by rst so nothing is offered as accepted while reset is held.
    assign in_ready   = rst && !halted_q && !br_taken && !halt_in_ex;
    assign accept     = in_valid && in_ready;
    assign wb_valid_d = id_valid_q && alu_ok && (rd_idx != '0);

    // ID register: load the accepted word, otherwise a bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_valid_q <= 1'b0;
            id_instr_q <= '0;
            id_pc_q    <= '0;
        end else begin
            id_valid_q <= accept;
            if (accept) begin
                id_instr_q <= in_instr;
                id_pc_q    <= in_pc;
            end
        end
    end

    // WB register: latch the EX result every cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
        end else begin
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= rd_idx;
            wb_data_q  <= alu_res;
        end
    end

    // Sticky halt: set once the halt word reaches EX.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            halted_q <= 1'b0;
        end else if (halt_in_ex) begin
            halted_q <= 1'b1;
        end
    end

    // Register file commit from WB; x0 is never written because wb_valid_q excludes it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < REG_DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wb_valid_q) begin
            regs_q[wb_rd_q] <= wb_data_q;
        end
    end

    assign res_valid = wb_valid_q;
    assign res_reg   = wb_rd_q;
    assign res_data  = wb_data_q;
    assign halted    = halted_q;
    assign dbg_data  = regs_q[dbg_addr];

endmodule
